pseudo_entropy_gen: RTL and testbench

//   Parametrised simulation-only entropy source for the TRNG mixer path. Provides NO real entropy.

---
 rtl/pseudo_entropy_pkg.sv | 22 ++
 rtl/pe_lfsr32.sv | 31 +++
 rtl/pseudo_entropy_gen.sv | 111 +++++++++++
 tb/tb_pseudo_entropy_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_entropy_pkg.sv
// Package shared by the simulation entropy sources.
// Holds the source FSM state type, the default LFSR seed/polynomial and the
// Galois LFSR step function used by pe_lfsr32.
`timescale 1ns/1ps
package pseudo_entropy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SYN  = 2'd2
  } pe_state_t;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] DEFAULT_POLY = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'h00000001;

  // One right-shifting Galois step: the bit shifted out selects the feedback mask.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] poly);
    return (s >> 1) ^ (s[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/pe_lfsr32.sv
// 32-bit Galois LFSR shared by the simulation entropy sources.
// Ports:
//   clk      in   1   clock
//   reset    in   1   asynchronous, active-high reset (loads the seed)
//   step_en  in   1   advance one step on this edge; state freezes otherwise
//   state    out  32  current LFSR state
`timescale 1ns/1ps
module pe_lfsr32
  import pseudo_entropy_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED,
  parameter logic [31:0] POLY = DEFAULT_POLY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_en,
  output logic [31:0] state
);

  // An all-zero state would lock the LFSR up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEED_EFF;
    end else if (step_en) begin
      state <= lfsr_step(state, POLY);
    end
  end

endmodule

// File: rtl/pseudo_entropy_gen.sv
// Simulation-only stand-in for a physical entropy source (provides NO real entropy).
// Presents words from a Galois LFSR (or a fixed pattern) on a syn/ack interface,
// rate-limited by a fill counter, and counts delivered words.
// Ports:
//   clk           in   1           clock
//   reset         in   1           asynchronous, active-high reset
//   enable        in   1           source enable
//   mode          in   1           0 = LFSR words, 1 = FIXED_PATTERN words
//   raw_entropy   out  32          live LFSR state while enable=1, else 0
//   stats         out  32          saturating count of acknowledged words
//   enabled       out  1           registered copy of enable
//   entropy_syn   out  1           word valid
//   entropy_data  out  DATA_WIDTH  word, stable while entropy_syn=1
//   entropy_ack   in   1           consumer accepts the word
`timescale 1ns/1ps
module pseudo_entropy_gen
  import pseudo_entropy_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] SEED          = DEFAULT_SEED,
  parameter logic [31:0] POLY          = DEFAULT_POLY,
  parameter int          WAIT_CYCLES   = 4,
  parameter logic [31:0] FIXED_PATTERN = 32'hf1e2d3c4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  output logic [31:0]           raw_entropy,
  output logic [31:0]           stats,
  output logic                  enabled,
  output logic                  entropy_syn,
  output logic [DATA_WIDTH-1:0] entropy_data,
  input  logic                  entropy_ack
);

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  pe_state_t   state;
  logic [7:0]  cnt;
  logic [31:0] lfsr_state;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffffffff) ? v : v + 32'd1;
  endfunction

  // The LFSR runs on every enabled cycle, independent of the handshake, and
  // simply freezes while disabled so re-enabling resumes the same sequence.
  pe_lfsr32 #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .step_en (enable),
    .state   (lfsr_state)
  );

  assign raw_entropy = enable ? lfsr_state : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      stats        <= 32'h0;
      enabled      <= 1'b0;
      entropy_syn  <= 1'b0;
      entropy_data <= '0;
    end else begin
      enabled <= enable;
      // Disable wins over everything, including an ack in the same cycle.
      if (!enable) begin
        state        <= IDLE;
        cnt          <= 8'd0;
        entropy_syn  <= 1'b0;
        entropy_data <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= FILL;
            cnt   <= WAIT_INIT;
          end
          FILL: begin
            if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end else begin
              // Capture the state produced by the LFSR's most recent step;
              // mode only matters on this edge.
              state        <= SYN;
              entropy_syn  <= 1'b1;
              entropy_data <= mode ? FIXED_PATTERN[DATA_WIDTH-1:0]
                                   : lfsr_state[DATA_WIDTH-1:0];
            end
          end
          SYN: begin
            if (entropy_ack) begin
              state       <= FILL;
              cnt         <= WAIT_INIT;
              entropy_syn <= 1'b0;
              stats       <= sat_inc(stats);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pseudo_entropy_gen.sv
`timescale 1ns/1ps
module tb_pseudo_entropy_gen;

  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic [31:0] FIX  = 32'hf1e2d3c4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic mode = 1'b0;
  logic ack = 1'b0;
  logic en_z = 1'b0;
  logic preset_req = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] raw0, stats0, data0, raw4, stats4, data4, rawz, statsz;
  logic [15:0] dataz;
  logic        syn0, enb0, syn4, enb4, synz, enbz;

  // dut0: WAIT_CYCLES=0, dut4: WAIT_CYCLES=4, dutz: SEED=0 build.
  pseudo_entropy_gen #(.DATA_WIDTH(32), .SEED(32'h1), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .raw_entropy(raw0), .stats(stats0), .enabled(enb0),
    .entropy_syn(syn0), .entropy_data(data0), .entropy_ack(ack));

  pseudo_entropy_gen #(.DATA_WIDTH(32), .SEED(32'h1), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .raw_entropy(raw4), .stats(stats4), .enabled(enb4),
    .entropy_syn(syn4), .entropy_data(data4), .entropy_ack(ack));

  pseudo_entropy_gen #(.DATA_WIDTH(16), .SEED(32'h0), .WAIT_CYCLES(0)) dutz (
    .clk(clk), .reset(reset), .enable(en_z), .mode(mode),
    .raw_entropy(rawz), .stats(statsz), .enabled(enbz),
    .entropy_syn(synz), .entropy_data(dataz), .entropy_ack(ack));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // Per source: LFSR value, whether a word is offered, the word itself,
  // remaining fill cycles (-1 = idle, no fill started), delivered count.
  logic [31:0] m_lfsr [2];
  logic [31:0] m_word [2];
  logic [31:0] m_stats[2];
  logic        m_valid[2];
  logic        m_en   [2];
  int          m_left [2];
  int          m_words[2];
  int          wait_of[2] = '{0, 4};

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] r;
    r = s / 2;
    if ((s % 2) != 0) r = r ^ POLY;
    return r;
  endfunction

  always @(posedge clk or posedge reset or posedge preset_req) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_lfsr[i] = 32'h1; m_word[i] = 0; m_stats[i] = 0; m_valid[i] = 0;
        m_en[i] = 0; m_left[i] = -1; m_words[i] = 0;
      end
    end else if (preset_req) begin
      m_stats[0] = 32'hfffffffe;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!enable) begin
          m_valid[i] = 0; m_word[i] = 0; m_left[i] = -1;
        end else if (m_valid[i]) begin
          if (ack) begin
            m_valid[i] = 0;
            if (m_stats[i] != 32'hffffffff) m_stats[i] = m_stats[i] + 1;
            m_words[i]++;
            m_left[i] = wait_of[i];
          end
        end else if (m_left[i] < 0) begin
          m_left[i] = wait_of[i];
        end else if (m_left[i] > 0) begin
          m_left[i]--;
        end else begin
          m_valid[i] = 1;
          m_word[i]  = mode ? FIX : m_lfsr[i];
        end
        if (enable) m_lfsr[i] = ref_step(m_lfsr[i]);
        m_en[i] = enable;
      end
    end
  end

  logic [31:0] o_raw[2], o_stats[2], o_data[2];
  logic        o_syn[2], o_enb[2];
  assign o_raw[0] = raw0;   assign o_raw[1] = raw4;
  assign o_stats[0] = stats0; assign o_stats[1] = stats4;
  assign o_data[0] = data0; assign o_data[1] = data4;
  assign o_syn[0] = syn0;   assign o_syn[1] = syn4;
  assign o_enb[0] = enb0;   assign o_enb[1] = enb4;

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("syn[%0d]", i), {31'b0, o_syn[i]}, {31'b0, m_valid[i]});
      chk($sformatf("stats[%0d]", i), o_stats[i], m_stats[i]);
      chk($sformatf("enabled[%0d]", i), {31'b0, o_enb[i]}, {31'b0, m_en[i]});
      chk($sformatf("raw[%0d]", i), o_raw[i], enable ? m_lfsr[i] : 32'h0);
      if (m_valid[i] || m_left[i] < 0)
        chk($sformatf("data[%0d]", i), o_data[i], m_word[i]);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  int start_words;
  int cycles;

  initial begin
    #1;
    reset = 1'b1; enable = 1'b1; mode = 1'b0; ack = 1'b0; en_z = 1'b1;
    cyc(); cyc();
    chk("rst_stats", stats0, 32'h0);
    chk("rst_syn", {31'b0, syn0}, 32'h0);
    chk("rst_data", data0, 32'h0);
    chk("rst_enabled", {31'b0, enb0}, 32'h0);
    chk("rst_raw_seed", raw0, 32'h1);
    chk("rst_seed0_raw", rawz, 32'h1);
    reset = 1'b0;

    // first word with WAIT_CYCLES=0
    cyc();
    chk("t1_syn_lat0", {31'b0, syn0}, 32'h0);
    chk("t1_seed0_step", rawz, 32'h80200003);
    en_z = 1'b0;
    cyc();
    chk("t1_syn", {31'b0, syn0}, 32'h1);
    chk("t1_data", data0, 32'h80200003);
    chk("t1_raw", raw0, 32'hc0300002);

    // fixed pattern, WAIT_CYCLES=4, ack pulsed while dut4 is filling
    enable = 1'b0; cyc();
    mode = 1'b1; enable = 1'b1;
    cyc(); cyc();
    ack = 1'b1; cyc();
    ack = 1'b0;
    chk("t3_fill_ack_ignored", stats4, 32'h0);
    chk("t3_dut0_acked", stats0, 32'h1);
    cyc(); cyc();
    chk("t2_syn_before5", {31'b0, syn4}, 32'h0);
    cyc();
    chk("t2_syn_at5", {31'b0, syn4}, 32'h1);
    chk("t2_data_fixed", data4, FIX);
    mode = 1'b0;
    repeat (20) cyc();
    chk("t2_hold_syn", {31'b0, syn4}, 32'h1);
    chk("t2_hold_data", data4, FIX);
    chk("t2_hold_stats", stats4, 32'h0);
    ack = 1'b1; cyc();
    ack = 1'b0;
    chk("t3_ack_stats", stats4, 32'h1);
    chk("t3_ack_syn_low", {31'b0, syn4}, 32'h0);
    repeat (5) cyc();
    chk("t3_resyn", {31'b0, syn4}, 32'h1);

    // enable dropped together with ack
    enable = 1'b0; ack = 1'b1; cyc();
    chk("t4_syn", {31'b0, syn4}, 32'h0);
    chk("t4_data", data4, 32'h0);
    chk("t4_stats", stats4, 32'h1);
    chk("t4_raw", raw4, 32'h0);
    chk("t4_enabled", {31'b0, enb4}, 32'h0);
    enable = 1'b1; ack = 1'b0;
    #0.5;
    chk("t4_lfsr_kept", raw4, m_lfsr[1]);

    // randomized traffic until dut0 delivered 1000 words
    start_words = m_words[0];
    cycles = 0;
    while ((m_words[0] - start_words) < 1000 && cycles < 20000) begin
      enable = ($urandom_range(0, 31) != 0);
      mode   = 1'($urandom_range(0, 1));
      ack    = 1'($urandom_range(0, 1));
      cyc();
      cycles++;
    end
    chk("rand_1000_words", {31'b0, ((m_words[0] - start_words) >= 1000)}, 32'h1);

    // saturation of the delivered-word counter
    enable = 1'b1; ack = 1'b1;
    cyc();
    force dut0.stats = 32'hfffffffe;
    preset_req = 1'b1;
    #0.5;
    release dut0.stats;
    preset_req = 1'b0;
    repeat (6) cyc();
    chk("t5_saturated", stats0, 32'hffffffff);
    ack = 1'b0;

    // asynchronous reset mid-FILL and mid-SYN
    enable = 1'b0; cyc();
    enable = 1'b1; cyc(); cyc();
    #2 reset = 1'b1;
    #1;
    chk("t6_fill_syn", {31'b0, syn4}, 32'h0);
    chk("t6_fill_data", data4, 32'h0);
    chk("t6_fill_stats", stats4, 32'h0);
    chk("t6_fill_enabled", {31'b0, enb4}, 32'h0);
    chk("t6_fill_raw", raw4, 32'h1);
    chk("t6_fill_stats0", stats0, 32'h0);
    cyc();
    reset = 1'b0;
    repeat (6) cyc();
    chk("t6_syn_up", {31'b0, syn4}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_syn_syn", {31'b0, syn4}, 32'h0);
    chk("t6_syn_data", data4, 32'h0);
    chk("t6_syn_syn0", {31'b0, syn0}, 32'h0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("z_syn", {31'b0, synz}, 32'h0);
    chk("z_data", {16'b0, dataz}, 32'h0);
    chk("z_stats", statsz, 32'h0);
    chk("z_enabled", {31'b0, enbz}, 32'h0);
    chk("z_raw_gated", rawz, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
